// File: rtl/l1_trig_pkg.sv
// Package shared by the L1 trigger collector files.
// Holds the beam count and datapath widths, the queued event record and the
// collector FSM state encoding. No ports.
package l1_trig_pkg;

  localparam int NBEAMS     = 46;  // beam trigger inputs, at most 64
  localparam int TS_W       = 32;  // timestamp width in clock cycles
  localparam int HOLDOFF_W  = 16;  // holdoff counter width
  localparam int SCALER_W   = 16;  // per-beam saturating scaler width
  localparam int FIFO_DEPTH = 16;  // event FIFO depth, power of 2
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int DROP_W     = 16;
  localparam int PERIOD_W   = 32;
  localparam int SEL_W      = 6;

  // One queued event: which enabled beams fired, and when.
  typedef struct packed {
    logic [NBEAMS-1:0] beams;
    logic [TS_W-1:0]   stamp;
  } evt_t;

  // IDLE is encoded as 0 so the debug state reads 0 out of reset.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } fsm_t;

endpackage

// File: rtl/l1_trigger_collector_if.sv
// Event readout bus between the trigger collector and its consumer.
//   evt_valid_o  collector -> consumer  FIFO head is valid
//   evt_ready_i  consumer -> collector  consumer accepts the head
//   evt_beams_o  collector -> consumer  masked beam bits of the head event
//   evt_time_o   collector -> consumer  timestamp of the head event
// Handshake: the head transfers on every rising edge where evt_valid_o and
// evt_ready_i are both 1. Once valid is high, valid and data hold until that
// transfer; valid never depends combinationally on ready.
interface l1_trigger_collector_if;
  import l1_trig_pkg::*;

  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [NBEAMS-1:0] evt_beams_o;
  logic [TS_W-1:0]   evt_time_o;

  modport master (output evt_valid_o, evt_beams_o, evt_time_o, input evt_ready_i);
  modport slave  (input evt_valid_o, evt_beams_o, evt_time_o, output evt_ready_i);

endinterface

// File: rtl/l1_evt_fifo.sv
// Synchronous show-ahead FIFO of evt_t records, depth FIFO_DEPTH.
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, din    write din when not full, or when full with a pop this cycle
//   pop          drop the head when not empty
//   dout         current head (meaningful only while empty is 0)
//   full, empty  occupancy flags
// A push into an empty FIFO appears on dout one cycle later (no bypass).
module l1_evt_fifo
  import l1_trig_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  evt_t din,
  output evt_t dout,
  output logic full,
  output logic empty
);

  evt_t               mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == {1'b1, {FIFO_AW{1'b0}}});
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one being popped this edge.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l1_trigger_collector.sv
// L1 trigger collector: registers per-beam trigger bits, applies the beam
// enable mask and a programmable holdoff, timestamps each accepted event and
// queues {beams, timestamp} for readout. Also keeps per-beam rate scalers
// latched into a shadow bank once per programmable period.
//   clk_i, rstn_i     clock, asynchronous active-low reset
//   trigger_i         per-beam trigger bits
//   beam_mask_i       1 = beam may generate events
//   holdoff_i         dead cycles after each accepted event
//   run_i             1 = event generation enabled
//   evt               readout bus (master side)
//   drop_count_o      events lost to a full FIFO, saturating
//   scaler_period_i   scaler period in cycles, 0 = halt
//   scaler_sel_i      beam index for scaler readback
//   scaler_o          latched scaler of selected beam, 1-cycle latency
//   scaler_upd_o      1-cycle pulse when the shadow bank is latched
//   fsm_state_o       debug view of the collector FSM state
module l1_trigger_collector
  import l1_trig_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NBEAMS-1:0]      trigger_i,
  input  logic [NBEAMS-1:0]      beam_mask_i,
  input  logic [HOLDOFF_W-1:0]   holdoff_i,
  input  logic                   run_i,
  l1_trigger_collector_if.master evt,
  output logic [DROP_W-1:0]      drop_count_o,
  input  logic [PERIOD_W-1:0]    scaler_period_i,
  input  logic [SEL_W-1:0]       scaler_sel_i,
  output logic [SCALER_W-1:0]    scaler_o,
  output logic                   scaler_upd_o,
  output fsm_t                   fsm_state_o
);

  fsm_t                 state, state_nx;
  logic [HOLDOFF_W-1:0] hcnt, hcnt_nx;
  logic [NBEAMS-1:0]    trig_q;
  logic [TS_W-1:0]      ts, ts_q;
  logic                 hit, accept, push, drop, pop, full, empty;
  evt_t                 din, head;
  logic [SCALER_W-1:0]  cnt    [NBEAMS];
  logic [SCALER_W-1:0]  shadow [NBEAMS];
  logic [PERIOD_W-1:0]  pcnt;
  logic                 period_end;

  // Input stage: ts_q is the timestamp of the cycle in which trigger_i was seen.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      trig_q <= '0;
      ts     <= '0;
      ts_q   <= '0;
    end else begin
      trig_q <= trigger_i;
      ts     <= ts + TS_W'(1);
      ts_q   <= ts;
    end
  end

  assign hit = |(trig_q & beam_mask_i);
  assign pop = ~empty & evt.evt_ready_i;

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
    end
  end

  // FSM next state; dropping run_i wins over a hit in the same cycle.
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    accept   = 1'b0;
    if (!run_i) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nx = ST_ARMED;
        ST_ARMED: begin
          if (hit) begin
            accept = 1'b1;
            if (holdoff_i != '0) begin
              state_nx = ST_HOLDOFF;
              hcnt_nx  = holdoff_i;
            end
          end
        end
        ST_HOLDOFF: begin
          // hcnt counts H..1, giving exactly H cycles in which hits are ignored.
          hcnt_nx = hcnt - HOLDOFF_W'(1);
          if (hcnt <= HOLDOFF_W'(1)) state_nx = ST_ARMED;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign push = accept & (~full | pop);
  assign drop = accept & full & ~pop;
  assign din  = '{beams: trig_q & beam_mask_i, stamp: ts_q};

  l1_evt_fifo u_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Head data is forced to 0 while empty so stale memory never shows.
  assign evt.evt_valid_o = ~empty;
  assign evt.evt_beams_o = empty ? '0 : head.beams;
  assign evt.evt_time_o  = empty ? '0 : head.stamp;
  assign fsm_state_o     = state;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                              drop_count_o <= '0;
    else if (drop && drop_count_o != '1)      drop_count_o <= drop_count_o + DROP_W'(1);
  end

  // Scalers count raw trig_q, independent of mask and FSM. On the terminal
  // cycle the bank is latched and counting restarts with that cycle's hit.
  assign period_end = (scaler_period_i != '0) && (pcnt >= scaler_period_i - PERIOD_W'(1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pcnt         <= '0;
      scaler_upd_o <= 1'b0;
      scaler_o     <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        cnt[b]    <= '0;
        shadow[b] <= '0;
      end
    end else begin
      scaler_upd_o <= period_end;
      scaler_o     <= (scaler_sel_i < SEL_W'(NBEAMS)) ? shadow[scaler_sel_i] : '0;
      if (period_end)                pcnt <= '0;
      else if (scaler_period_i != '0) pcnt <= pcnt + PERIOD_W'(1);
      for (int b = 0; b < NBEAMS; b++) begin
        if (period_end) begin
          shadow[b] <= cnt[b];
          cnt[b]    <= SCALER_W'(trig_q[b]);
        end else if (scaler_period_i != '0 && trig_q[b] && cnt[b] != '1) begin
          cnt[b] <= cnt[b] + SCALER_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_l1_trigger_collector.sv
// Directed bench for l1_trigger_collector. Inputs change on the falling edge
// and outputs are sampled there. tb_ts is a free-running cycle number that
// restarts on reset, so "cycle N" below means the cycle in which the
// collector's timestamp reads N.
module tb_l1_trigger_collector;
  import l1_trig_pkg::*;

  localparam int EVT_W = NBEAMS + TS_W;

  logic                 clk;
  logic                 rstn;
  logic [NBEAMS-1:0]    trigger;
  logic [NBEAMS-1:0]    beam_mask;
  logic [HOLDOFF_W-1:0] holdoff;
  logic                 run;
  logic [DROP_W-1:0]    drop_count;
  logic [PERIOD_W-1:0]  scaler_period;
  logic [SEL_W-1:0]     scaler_sel;
  logic [SCALER_W-1:0]  scaler;
  logic                 scaler_upd;
  fsm_t                 state_dbg;
  logic [TS_W-1:0]      tb_ts;

  int vectors     = 0;
  int miscompares = 0;
  int seen        = 0;
  logic [EVT_W-1:0] exp_q[$];

  l1_trigger_collector_if evt_if ();

  l1_trigger_collector dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .trigger_i       (trigger),
    .beam_mask_i     (beam_mask),
    .holdoff_i       (holdoff),
    .run_i           (run),
    .evt             (evt_if),
    .drop_count_o    (drop_count),
    .scaler_period_i (scaler_period),
    .scaler_sel_i    (scaler_sel),
    .scaler_o        (scaler),
    .scaler_upd_o    (scaler_upd),
    .fsm_state_o     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ts(input int t);
    for (int i = 0; i < 2000 && tb_ts != TS_W'(t); i++) tick();
    check("wait_ts", tb_ts, t);
  endtask

  function automatic logic [NBEAMS-1:0] oh(input int b);
    logic [NBEAMS-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares the head against the expected queue; caller holds ready high.
  task automatic observe_head(input bit chk_lat);
    logic [EVT_W-1:0] e;
    if (evt_if.evt_valid_o) begin
      seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_evt", evt_if.evt_valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("evt_data", {evt_if.evt_beams_o, evt_if.evt_time_o}, e);
        if (chk_lat) check("evt_latency", tb_ts - evt_if.evt_time_o, 2);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0; trigger = '0; beam_mask = '0; holdoff = '0; run = 1'b0;
    scaler_period = '0; scaler_sel = '0; evt_if.evt_ready_i = 1'b0;
    repeat (3) tick();

    check("rst_valid", evt_if.evt_valid_o, 0);
    check("rst_beams", evt_if.evt_beams_o, 0);
    check("rst_time", evt_if.evt_time_o, 0);
    check("rst_drop", drop_count, 0);
    check("rst_scaler", scaler, 0);
    check("rst_upd", scaler_upd, 0);
    check("rst_state", state_dbg, ST_IDLE);

    // Scalers: beam 5 masked off, high for cycles 10..16, period 50.
    scaler_period = 50; run = 1'b1; scaler_sel = 6'd5; evt_if.evt_ready_i = 1'b1;
    rstn = 1'b1;
    wait_ts(10); trigger = oh(5);
    wait_ts(17); trigger = '0;
    wait_ts(49);
    check("upd_before", scaler_upd, 0);
    wait_ts(50);
    check("upd_pulse", scaler_upd, 1);
    check("scaler_old", scaler, 0);
    tick();
    check("upd_after", scaler_upd, 0);
    check("scaler_b5", scaler, 7);
    check("masked_no_evt", evt_if.evt_valid_o, 0);
    check("masked_no_drop", drop_count, 0);
    scaler_sel = 6'd46;
    tick();
    check("scaler_sel_oob", scaler, 0);
    scaler_sel = 6'd5;
    tick();
    check("scaler_reselect", scaler, 7);
    scaler_period = '0;

    // Single event, holdoff 0: trigger in cycle 100, valid in cycle 102.
    wait_ts(60); beam_mask = '1;
    wait_ts(100); trigger = oh(3);
    tick(); trigger = '0;
    check("lat_not_yet", evt_if.evt_valid_o, 0);
    check("state_armed", state_dbg, ST_ARMED);
    tick();
    check("lat_valid", evt_if.evt_valid_o, 1);
    check("single_evt", {evt_if.evt_beams_o, evt_if.evt_time_o}, {oh(3), 32'd100});
    tick();
    check("single_pop", evt_if.evt_valid_o, 0);
    repeat (5) tick();
    check("single_only", evt_if.evt_valid_o, 0);

    // Holdoff 10, beam 7 held for cycles 120..149: events at 120, 131, 142.
    wait_ts(120); holdoff = 16'd10; trigger = oh(7);
    exp_q.push_back({oh(7), 32'd120});
    exp_q.push_back({oh(7), 32'd131});
    exp_q.push_back({oh(7), 32'd142});
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      if (tb_ts == 150) trigger = '0;
      observe_head(1'b1);
      tick();
    end
    check("holdoff_count", seen, 3);
    check("holdoff_left", exp_q.size(), 0);
    holdoff = '0;

    // Ready low, 20 hits two cycles apart from 170: 16 queued, 4 dropped.
    wait_ts(170); evt_if.evt_ready_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      trigger = oh(k);
      if (k < 16) exp_q.push_back({oh(k), TS_W'(170 + 2 * k)});
      tick();
      trigger = '0;
      tick();
    end
    repeat (2) tick();
    check("full_drops", drop_count, 4);
    check("full_valid", evt_if.evt_valid_o, 1);
    check("full_head", {evt_if.evt_beams_o, evt_if.evt_time_o}, exp_q[0]);
    evt_if.evt_ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      observe_head(1'b0);
      tick();
    end
    check("drain_count", seen, 16);
    check("drain_empty", evt_if.evt_valid_o, 0);

    // run_i dropped in the cycle the hit is seen: no event, back to IDLE.
    wait_ts(260); trigger = oh(9);
    tick(); trigger = '0; run = 1'b0;
    tick();
    check("run_drop_state", state_dbg, ST_IDLE);
    check("run_drop_nopush", evt_if.evt_valid_o, 0);
    tick();
    check("run_drop_nopush2", evt_if.evt_valid_o, 0);
    run = 1'b1;
    tick();
    check("rearm_state", state_dbg, ST_ARMED);
    trigger = oh(9);
    tick(); trigger = '0;
    tick();
    check("rearm_evt", {evt_if.evt_beams_o, evt_if.evt_time_o}, {oh(9), 32'd264});
    tick();

    // Full FIFO, hit and pop in the same cycle: accepted, no drop.
    wait_ts(280); evt_if.evt_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      trigger = oh(k + 20);
      exp_q.push_back({oh(k + 20), TS_W'(280 + 2 * k)});
      tick();
      trigger = '0;
      tick();
    end
    repeat (2) tick();
    check("refill_drops", drop_count, 4);
    trigger = oh(40);
    tick();
    trigger = '0; evt_if.evt_ready_i = 1'b1;
    seen = 0;
    observe_head(1'b0);
    exp_q.push_back({oh(40), 32'd314});
    tick();
    evt_if.evt_ready_i = 1'b0;
    check("pushpop_nodrop", drop_count, 4);
    evt_if.evt_ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      observe_head(1'b0);
      tick();
    end
    check("pushpop_count", seen, 16);
    check("pushpop_left", exp_q.size(), 0);

    // Asynchronous reset in the middle of a burst.
    evt_if.evt_ready_i = 1'b0; trigger = '1;
    repeat (3) tick();
    check("burst_valid", evt_if.evt_valid_o, 1);
    check("burst_scaler", scaler, 7);
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", evt_if.evt_valid_o, 0);
    check("arst_beams", evt_if.evt_beams_o, 0);
    check("arst_time", evt_if.evt_time_o, 0);
    check("arst_drop", drop_count, 0);
    check("arst_scaler", scaler, 0);
    check("arst_upd", scaler_upd, 0);
    check("arst_state", state_dbg, ST_IDLE);
    trigger = '0;
    tick();
    check("arst_hold", evt_if.evt_valid_o, 0);
    rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
